pipeline_hazard_ctrl: RTL and testbench

Issue controller for the RISC-V ID stage: decides each cycle whether the instruction in ID issues into ID/EX, stalls, or is squashed. Tracks in-flight register writes in a per-register scoreboard (set at issue, cleared at write-back) to resolve RAW and WAW hazards without forwarding. Runs a small flush state machine on taken-branch/jump redirects from EX. Drives the IF/ID and ID/EX pipeline-register enables/clears.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 74 +++++++
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the ID-stage issue controller.
//   REG_COUNT    : number of architectural integer registers
//   REG_IDX_W    : width of a register index
//   ctrl_state_t : controller states (RUN, FLUSH)
//   is_nonzero_reg() : true for any register other than x0
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  // x0 is hard-wired to zero, so it never carries a hazard.
  function automatic logic is_nonzero_reg(input logic [REG_IDX_W-1:0] idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the issue controller
// (slave).
//   ID inputs  : id_valid, id_rs1/id_rs2, id_uses_rs1/id_uses_rs2, id_rd,
//                id_write_back
//   WB inputs  : wb_reg_write, wb_rd
//   EX input   : redirect
//   Outputs    : issue, stall_if_id, bubble_id_ex, flush_if_id, stall_cycles
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                 id_valid;
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_uses_rs1;
  logic                 id_uses_rs2;
  logic [REG_IDX_W-1:0] id_rd;
  logic                 id_write_back;
  logic                 wb_reg_write;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 redirect;
  logic                 issue;
  logic                 stall_if_id;
  logic                 bubble_id_ex;
  logic                 flush_if_id;
  logic [31:0]          stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_write_back, wb_reg_write, wb_rd, redirect,
    input  issue, stall_if_id, bubble_id_ex, flush_if_id, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_write_back, wb_reg_write, wb_rd, redirect,
    output issue, stall_if_id, bubble_id_ex, flush_if_id, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Per-register count of in-flight writers. A counter rises when a writer
// issues and falls when its write-back happens; a non-zero count marks the
// register as not yet readable from the register file.
//   clk, rst             : clock, synchronous active-high reset
//   i_inc_en/i_inc_idx   : writer issued to this register
//   i_dec_en/i_dec_idx   : write-back to this register
//   i_rd_a_idx/o_rd_a_busy, i_rd_b_idx/o_rd_b_busy : source busy lookups
//   i_sat_idx/o_sat      : destination counter saturated
// Reads return the value before this cycle's update.
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc_en,
  input  logic [REG_IDX_W-1:0] i_inc_idx,
  input  logic                 i_dec_en,
  input  logic [REG_IDX_W-1:0] i_dec_idx,
  input  logic [REG_IDX_W-1:0] i_rd_a_idx,
  input  logic [REG_IDX_W-1:0] i_rd_b_idx,
  input  logic [REG_IDX_W-1:0] i_sat_idx,
  output logic                 o_rd_a_busy,
  output logic                 o_rd_b_busy,
  output logic                 o_sat
);

  logic [PEND_W-1:0]    r_pend [REG_COUNT];
  logic [REG_COUNT-1:0] w_inc_hit;
  logic [REG_COUNT-1:0] w_dec_hit;

  // One-hot decode of the increment and decrement targets; x0 is excluded.
  always_comb begin
    w_inc_hit = '0;
    w_dec_hit = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      w_inc_hit[r] = i_inc_en && is_nonzero_reg(i_inc_idx) &&
                     (i_inc_idx == REG_IDX_W'(r));
      w_dec_hit[r] = i_dec_en && is_nonzero_reg(i_dec_idx) &&
                     (i_dec_idx == REG_IDX_W'(r));
    end
  end

  // Counter update: issue and write-back on the same register cancel out.
  // The decrement floor guards against a stray write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        r_pend[r] <= '0;
      end
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        if (w_inc_hit[r] && !w_dec_hit[r]) begin
          r_pend[r] <= r_pend[r] + PEND_W'(1);
        end else if (w_dec_hit[r] && !w_inc_hit[r] && (r_pend[r] != '0)) begin
          r_pend[r] <= r_pend[r] - PEND_W'(1);
        end
      end
    end
  end

  assign o_rd_a_busy = (r_pend[i_rd_a_idx] != '0);
  assign o_rd_b_busy = (r_pend[i_rd_b_idx] != '0);
  assign o_sat       = (r_pend[i_sat_idx] == '1);

  // A write-back must always belong to an issued writer.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (i_dec_en && is_nonzero_reg(i_dec_idx)) |-> (r_pend[i_dec_idx] != '0));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// ID-stage issue controller: each cycle the ID instruction issues, stalls
// (RAW or scoreboard-full hazard) or is squashed by a redirect from EX.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipeline_hazard_ctrl_if.slave (ID/WB/EX inputs, control outs)
// Parameters: PEND_W (in-flight counter width), FLUSH_CYCLES (flush length,
// redirect cycle included).
// Optional macro HAZARD_STALL_CNT_EN enables the stall_cycles counter;
// without it stall_cycles reads 0.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int PEND_W       = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int             CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [0:0]     ST_RUN     = RUN;
  localparam logic [0:0]     ST_FLUSH   = FLUSH;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;

  logic w_rs1_busy;
  logic w_rs2_busy;
  logic w_rd_sat;
  logic w_hazard_raw;
  logic w_hazard_full;
  logic w_issue;
  logic w_stall;
  logic w_bubble;
  logic w_flush;

  hazard_scoreboard #(
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_inc_en    (w_issue && bus.id_write_back),
    .i_inc_idx   (bus.id_rd),
    .i_dec_en    (bus.wb_reg_write),
    .i_dec_idx   (bus.wb_rd),
    .i_rd_a_idx  (bus.id_rs1),
    .i_rd_b_idx  (bus.id_rs2),
    .i_sat_idx   (bus.id_rd),
    .o_rd_a_busy (w_rs1_busy),
    .o_rd_b_busy (w_rs2_busy),
    .o_sat       (w_rd_sat)
  );

  assign w_hazard_raw  = (bus.id_uses_rs1 && is_nonzero_reg(bus.id_rs1) && w_rs1_busy) ||
                         (bus.id_uses_rs2 && is_nonzero_reg(bus.id_rs2) && w_rs2_busy);
  assign w_hazard_full = bus.id_write_back && is_nonzero_reg(bus.id_rd) && w_rd_sat;

  // Pipeline control decode. Reset forces the pipe into its flushed shape;
  // a redirect beats any stall because the stalled instruction is wrong-path.
  always_comb begin
    w_issue  = 1'b0;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (rst || bus.redirect || (r_state == ST_FLUSH)) begin
      w_bubble = 1'b1;
      w_flush  = 1'b1;
    end else begin
      w_issue = bus.id_valid && !w_hazard_raw && !w_hazard_full;
      if (bus.id_valid && !w_issue) begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
      end
    end
  end

  // Flush sequencing. The redirect cycle is the first flush cycle, so the
  // FLUSH state returns to RUN once the counter has run down to 1 or 0.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    if (bus.redirect) begin
      w_state_nxt     = ST_FLUSH;
      w_flush_cnt_nxt = FLUSH_LOAD;
    end else if (r_state == ST_FLUSH) begin
      if (r_flush_cnt <= CNT_W'(1)) begin
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = '0;
      end else begin
        w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
      end
    end
  end

  // State and flush counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  assign bus.issue        = w_issue;
  assign bus.stall_if_id  = w_stall;
  assign bus.bubble_id_ex = w_bubble;
  assign bus.flush_if_id  = w_flush;

`ifdef HAZARD_STALL_CNT_EN
  logic        w_stall_event;
  logic [31:0] r_stall_cnt;

  assign w_stall_event = (r_state == ST_RUN) && bus.id_valid && !w_issue && !bus.redirect;

  // Saturating count of hazard stall cycles, for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_event && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cnt;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl (PEND_W=2, FLUSH_CYCLES=2).
// Honours HAZARD_STALL_CNT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  import pipeline_ctrl_pkg::*;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wbk;
    logic       wbw;
    logic [4:0] wbrd;
    logic       redir;
    logic [3:0] exp;   // {issue, stall_if_id, bubble_id_ex, flush_if_id}
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  out;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  pipeline_hazard_ctrl_if bus ();

  vec_t        vecs[$];
  exp_t        expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expStallCnt = 0;

  pipeline_hazard_ctrl #(
    .PEND_W       (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Append one cycle of stimulus with its hand-derived control outputs.
  task automatic addVec(input string n, input logic r, input logic v,
                        input logic [4:0] a, input logic ua,
                        input logic [4:0] b, input logic ub,
                        input logic [4:0] d, input logic wk,
                        input logic ww, input logic [4:0] wd,
                        input logic rdr, input logic [3:0] e);
    vec_t t;
    t.name = n; t.rst = r; t.valid = v; t.rs1 = a; t.u1 = ua; t.rs2 = b;
    t.u2 = ub; t.rd = d; t.wbk = wk; t.wbw = ww; t.wbrd = wd; t.redir = rdr;
    t.exp = e;
    vecs.push_back(t);
  endtask

  // Drive one vector just after the rising edge and queue its expectation.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rst               = v.rst;
    bus.id_valid      = v.valid;
    bus.id_rs1        = v.rs1;
    bus.id_uses_rs1   = v.u1;
    bus.id_rs2        = v.rs2;
    bus.id_uses_rs2   = v.u2;
    bus.id_rd         = v.rd;
    bus.id_write_back = v.wbk;
    bus.wb_reg_write  = v.wbw;
    bus.wb_rd         = v.wbrd;
    bus.redirect      = v.redir;
    e.name = v.name;
    e.out  = v.exp;
    e.cnt  = expStallCnt;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [3:0] act;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e   = expQ.pop_front();
    act = {bus.issue, bus.stall_if_id, bus.bubble_id_ex, bus.flush_if_id};
    if (act !== e.out) begin
      failCount++;
      $display("[TB] FAIL %s: ctrl {issue,stall,bubble,flush} got %b expected %b",
               e.name, act, e.out);
    end
    assertCount++;
    if (bus.stall_cycles !== e.cnt) begin
      failCount++;
      $display("[TB] FAIL %s_cnt: stall_cycles got %0d expected %0d",
               e.name, bus.stall_cycles, e.cnt);
    end
  endtask

  // Main sequence: table of single cycles, then a hand-timed flush check.
  initial begin
    int flushN;
    bit timedOut;

    rst = 1'b1;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_uses_rs1 = 0; bus.id_rs2 = 0;
    bus.id_uses_rs2 = 0; bus.id_rd = 0; bus.id_write_back = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.redirect = 0;

    //      name            rst v  rs1 u1 rs2 u2 rd wbk wbw wbrd rdr  exp
    addVec("reset0",         1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011);
    addVec("reset1",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011);
    addVec("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    addVec("read_x5_free",   0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    addVec("add_x5",         0, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 4'b1000);
    addVec("raw_x5_a",       0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 4'b0110);
    addVec("raw_x5_b",       0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 4'b0110);
    addVec("raw_x5_wb",      0, 1, 5, 1, 0, 0, 6, 1, 1, 5, 0, 4'b0110);
    addVec("raw_x5_go",      0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 4'b1000);
    addVec("x0_write",       0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b1000);
    addVec("x0_read",        0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b1000);
    addVec("rs2_unused",     0, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 4'b1000);
    addVec("rs2_raw",        0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 4'b0110);
    addVec("wb_x6",          0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 4'b0000);
    addVec("x7_w1",          0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b1000);
    addVec("x7_w2",          0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b1000);
    addVec("x7_w3",          0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b1000);
    addVec("x7_full",        0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b0110);
    addVec("x7_full_wb",     0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 4'b0110);
    addVec("x7_w4",          0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b1000);
    addVec("raw_x7",         0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 4'b0110);
    addVec("redir_stalled",  0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 4'b0011);
    addVec("flush_1",        0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 4'b0011);
    addVec("raw_x7_again",   0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
    addVec("x8_untouched",   0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    addVec("add_x9",         0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 4'b1000);
    addVec("x9_inc_dec",     0, 1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 4'b1000);
    addVec("raw_x9",         0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
    addVec("raw_x9_wb",      0, 1, 9, 1, 0, 0, 0, 0, 1, 9, 0, 4'b0110);
    addVec("x9_go",          0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    addVec("redir_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011);
    addVec("flush_2",        0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011);
    addVec("run_again",      0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    addVec("redir_pre_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011);
    addVec("rst_in_flush",   1, 1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 4'b0011);
    addVec("post_rst_x7",    0, 1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 4'b1000);
    addVec("stall_1",        0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
    addVec("stall_2",        0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
    addVec("stall_3",        0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
    addVec("stall_4",        0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
    addVec("stall_5_wb",     0, 1, 7, 1, 0, 0, 0, 0, 1, 7, 0, 4'b0110);
    addVec("stall_release",  0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    addVec("final_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

    @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      // Stall counter model: a stall_if_id cycle is exactly a counted cycle.
      if (vecs[i].rst) expStallCnt = 0;
      else if (CNT_EN && vecs[i].exp[2]) expStallCnt = expStallCnt + 1;
    end

    // Redirect from idle RUN: flush_if_id must stay high for exactly two
    // cycles (redirect cycle plus one FLUSH cycle), bounded wait.
    #1;
    bus.id_valid = 1'b0;
    bus.redirect = 1'b1;
    @(negedge clk);
    flushN = bus.flush_if_id ? 1 : 0;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    timedOut = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.flush_if_id) begin
        timedOut = 1'b0;
        break;
      end
      flushN++;
      @(posedge clk);
      #1;
    end
    assertCount++;
    if (timedOut) begin
      failCount++;
      $display("[TB] FAIL flush_timeout: flush_if_id still high after 10 cycles");
    end
    assertCount++;
    if (flushN != 2) begin
      failCount++;
      $display("[TB] FAIL flush_length: got %0d cycles expected 2", flushN);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
